ysyx_23060208_axi_arb: RTL and testbench

Parametrised N-master to 1-slave AXI4 arbiter, the successor to the fixed two-master (IFU/EXU) interconnect in the core top level. It owns independent read and write arbitration with burst locking, per-master completion pulses and selectable fairness. Masters are IFU, EXU and future agents such as a DMA or cache refill unit; the single slave port drives the core's `io_master_*` bus.

---
 rtl/ysyx_23060208_axi_arb.sv | 263 ++++++++++++++++++++++++++
 tb/tb_ysyx_23060208_axi_arb.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060208_axi_arb.sv
// ysyx_23060208_axi_arb: N-master to 1-slave AXI4 arbiter with independent, burst-locked read/write grants.
// Define YSYX_23060208_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (master 0 highest).
module ysyx_23060208_axi_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_MST    = 2,
  parameter int ID_WIDTH   = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  // master AR / R
  input  logic [NUM_MST-1:0]               m_arvalid,
  output logic [NUM_MST-1:0]               m_arready,
  input  logic [NUM_MST*DATA_WIDTH-1:0]    m_araddr,
  input  logic [NUM_MST*ID_WIDTH-1:0]      m_arid,
  input  logic [NUM_MST*8-1:0]             m_arlen,
  input  logic [NUM_MST*3-1:0]             m_arsize,
  input  logic [NUM_MST*2-1:0]             m_arburst,
  output logic [NUM_MST-1:0]               m_rvalid,
  input  logic [NUM_MST-1:0]               m_rready,
  output logic [DATA_WIDTH*2-1:0]          m_rdata,
  output logic [1:0]                       m_rresp,
  output logic                             m_rlast,
  output logic [ID_WIDTH-1:0]              m_rid,
  // master AW / W / B
  input  logic [NUM_MST-1:0]               m_awvalid,
  output logic [NUM_MST-1:0]               m_awready,
  input  logic [NUM_MST*DATA_WIDTH-1:0]    m_awaddr,
  input  logic [NUM_MST*ID_WIDTH-1:0]      m_awid,
  input  logic [NUM_MST*8-1:0]             m_awlen,
  input  logic [NUM_MST*3-1:0]             m_awsize,
  input  logic [NUM_MST*2-1:0]             m_awburst,
  input  logic [NUM_MST-1:0]               m_wvalid,
  output logic [NUM_MST-1:0]               m_wready,
  input  logic [NUM_MST*DATA_WIDTH*2-1:0]  m_wdata,
  input  logic [NUM_MST*(DATA_WIDTH/4)-1:0] m_wstrb,
  input  logic [NUM_MST-1:0]               m_wlast,
  output logic [NUM_MST-1:0]               m_bvalid,
  input  logic [NUM_MST-1:0]               m_bready,
  output logic [1:0]                       m_bresp,
  output logic [ID_WIDTH-1:0]              m_bid,
  // completion pulses
  output logic [NUM_MST-1:0]               rd_done,
  output logic [NUM_MST-1:0]               wr_done,
  // slave port
  output logic                             s_arvalid,
  input  logic                             s_arready,
  output logic [DATA_WIDTH-1:0]            s_araddr,
  output logic [ID_WIDTH-1:0]              s_arid,
  output logic [7:0]                       s_arlen,
  output logic [2:0]                       s_arsize,
  output logic [1:0]                       s_arburst,
  input  logic                             s_rvalid,
  output logic                             s_rready,
  input  logic [DATA_WIDTH*2-1:0]          s_rdata,
  input  logic [1:0]                       s_rresp,
  input  logic                             s_rlast,
  input  logic [ID_WIDTH-1:0]              s_rid,
  output logic                             s_awvalid,
  input  logic                             s_awready,
  output logic [DATA_WIDTH-1:0]            s_awaddr,
  output logic [ID_WIDTH-1:0]              s_awid,
  output logic [7:0]                       s_awlen,
  output logic [2:0]                       s_awsize,
  output logic [1:0]                       s_awburst,
  output logic                             s_wvalid,
  input  logic                             s_wready,
  output logic [DATA_WIDTH*2-1:0]          s_wdata,
  output logic [DATA_WIDTH/4-1:0]          s_wstrb,
  output logic                             s_wlast,
  input  logic                             s_bvalid,
  output logic                             s_bready,
  input  logic [1:0]                       s_bresp,
  input  logic [ID_WIDTH-1:0]              s_bid
);

  localparam int unsigned NM = NUM_MST;
  localparam int GW = $clog2(NUM_MST);
  localparam int DW = DATA_WIDTH * 2;
  localparam int SW = DATA_WIDTH / 4;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} wstate_t;

  rstate_t            rstate;
  wstate_t            wstate;
  logic [GW-1:0]      rgnt, wgnt, r_win, w_win;
  logic [NUM_MST-1:0] r_sel, w_sel;
  logic               aw_ok, w_ok, aw_hs, w_last_hs;

`ifdef YSYX_23060208_ARB_RR_EN
  logic [GW-1:0] rptr, wptr;

  function automatic logic [GW-1:0] pick(input logic [NUM_MST-1:0] req, input logic [GW-1:0] ptr);
    logic [GW-1:0] win;
    logic [GW-1:0] idx;
    logic          found;
    win   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NM; k++) begin
      idx = GW'((int unsigned'(ptr) + k) % NM);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  function automatic logic [GW-1:0] next_ptr(input logic [GW-1:0] win);
    return (int unsigned'(win) == NM - 1) ? '0 : win + 1'b1;
  endfunction

  assign r_win = pick(m_arvalid, rptr);
  assign w_win = pick(m_awvalid, wptr);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rptr <= '0;
      wptr <= '0;
    end else begin
      if (rstate == R_IDLE && |m_arvalid) rptr <= next_ptr(r_win);
      if (wstate == W_IDLE && |m_awvalid) wptr <= next_ptr(w_win);
    end
  end
`else
  function automatic logic [GW-1:0] pick(input logic [NUM_MST-1:0] req);
    logic [GW-1:0] win;
    logic          found;
    win   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NM; i++) begin
      if (!found && req[i]) begin
        win   = GW'(i);
        found = 1'b1;
      end
    end
    return win;
  endfunction

  assign r_win = pick(m_arvalid);
  assign w_win = pick(m_awvalid);
`endif

  // Read path: grant mux, payload pass-through and handshake gating
  always_comb begin
    r_sel     = '0;
    s_araddr  = '0;
    s_arid    = '0;
    s_arlen   = '0;
    s_arsize  = '0;
    s_arburst = '0;
    for (int unsigned i = 0; i < NM; i++) begin
      if (GW'(i) == rgnt) begin
        r_sel[i]  = 1'b1;
        s_araddr  = m_araddr[i*DATA_WIDTH +: DATA_WIDTH];
        s_arid    = m_arid[i*ID_WIDTH +: ID_WIDTH];
        s_arlen   = m_arlen[i*8 +: 8];
        s_arsize  = m_arsize[i*3 +: 3];
        s_arburst = m_arburst[i*2 +: 2];
      end
    end
    s_arvalid = (rstate == R_ADDR) & |(m_arvalid & r_sel);
    m_arready = (rstate == R_ADDR && s_arready) ? r_sel : '0;
    m_rvalid  = (rstate == R_DATA && s_rvalid) ? r_sel : '0;
    s_rready  = (rstate == R_DATA) & |(m_rready & r_sel);
  end

  assign m_rdata = s_rdata;
  assign m_rresp = s_rresp;
  assign m_rlast = s_rlast;
  assign m_rid   = s_rid;

  // Write path: AW and W are forwarded side by side; each is masked once it has completed
  always_comb begin
    w_sel     = '0;
    s_awaddr  = '0;
    s_awid    = '0;
    s_awlen   = '0;
    s_awsize  = '0;
    s_awburst = '0;
    s_wdata   = '0;
    s_wstrb   = '0;
    s_wlast   = 1'b0;
    for (int unsigned i = 0; i < NM; i++) begin
      if (GW'(i) == wgnt) begin
        w_sel[i]  = 1'b1;
        s_awaddr  = m_awaddr[i*DATA_WIDTH +: DATA_WIDTH];
        s_awid    = m_awid[i*ID_WIDTH +: ID_WIDTH];
        s_awlen   = m_awlen[i*8 +: 8];
        s_awsize  = m_awsize[i*3 +: 3];
        s_awburst = m_awburst[i*2 +: 2];
        s_wdata   = m_wdata[i*DW +: DW];
        s_wstrb   = m_wstrb[i*SW +: SW];
        s_wlast   = m_wlast[i];
      end
    end
    s_awvalid = (wstate == W_REQ) & ~aw_ok & |(m_awvalid & w_sel);
    m_awready = (wstate == W_REQ && !aw_ok && s_awready) ? w_sel : '0;
    s_wvalid  = (wstate == W_REQ) & ~w_ok & |(m_wvalid & w_sel);
    m_wready  = (wstate == W_REQ && !w_ok && s_wready) ? w_sel : '0;
    m_bvalid  = (wstate == W_RESP && s_bvalid) ? w_sel : '0;
    s_bready  = (wstate == W_RESP) & |(m_bready & w_sel);
    aw_hs     = s_awvalid & s_awready;
    w_last_hs = s_wvalid & s_wready & s_wlast;
  end

  assign m_bresp = s_bresp;
  assign m_bid   = s_bid;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rstate  <= R_IDLE;
      rgnt    <= '0;
      rd_done <= '0;
    end else begin
      rd_done <= '0;
      case (rstate)
        R_IDLE: if (|m_arvalid) begin
          rgnt   <= r_win;
          rstate <= R_ADDR;
        end
        R_ADDR: if (s_arvalid && s_arready) rstate <= R_DATA;
        R_DATA: if (s_rvalid && s_rready && s_rlast) begin
          rd_done <= r_sel;
          rstate  <= R_IDLE;
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  // Response phase is entered in the cycle the later of AW / W-last completes
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wstate  <= W_IDLE;
      wgnt    <= '0;
      aw_ok   <= 1'b0;
      w_ok    <= 1'b0;
      wr_done <= '0;
    end else begin
      wr_done <= '0;
      case (wstate)
        W_IDLE: if (|m_awvalid) begin
          wgnt   <= w_win;
          wstate <= W_REQ;
        end
        W_REQ: begin
          if (aw_hs) aw_ok <= 1'b1;
          if (w_last_hs) w_ok <= 1'b1;
          if ((aw_ok || aw_hs) && (w_ok || w_last_hs)) wstate <= W_RESP;
        end
        W_RESP: if (s_bvalid && s_bready) begin
          wr_done <= w_sel;
          aw_ok   <= 1'b0;
          w_ok    <= 1'b0;
          wstate  <= W_IDLE;
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060208_axi_arb.sv
// Self-checking bench for ysyx_23060208_axi_arb (2 masters): directed tables, hand-written corner sequences
// and randomized read traffic checked against a request-set arbitration model.
module tb_ysyx_23060208_axi_arb;
  localparam int NM = 2;

  logic          clock, reset;
  logic [1:0]    m_arvalid, m_arready, m_rvalid, m_rready;
  logic [63:0]   m_araddr, m_awaddr;
  logic [7:0]    m_arid, m_awid;
  logic [15:0]   m_arlen, m_awlen;
  logic [5:0]    m_arsize, m_awsize;
  logic [3:0]    m_arburst, m_awburst;
  logic [63:0]   m_rdata;
  logic [1:0]    m_rresp, m_bresp;
  logic          m_rlast;
  logic [3:0]    m_rid, m_bid;
  logic [1:0]    m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
  logic [127:0]  m_wdata;
  logic [15:0]   m_wstrb;
  logic [1:0]    rd_done, wr_done;
  logic          s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
  logic [31:0]   s_araddr, s_awaddr;
  logic [3:0]    s_arid, s_rid, s_awid, s_bid;
  logic [7:0]    s_arlen, s_awlen, s_wstrb;
  logic [2:0]    s_arsize, s_awsize;
  logic [1:0]    s_arburst, s_awburst, s_rresp, s_bresp;
  logic [63:0]   s_rdata, s_wdata;
  logic          s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;

  ysyx_23060208_axi_arb #(.DATA_WIDTH(32), .NUM_MST(NM), .ID_WIDTH(4)) dut (
    .clock(clock), .reset(reset),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arid(m_arid),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .m_rid(m_rid),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awid(m_awid),
    .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp), .m_bid(m_bid),
    .rd_done(rd_done), .wr_done(wr_done),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rlast(s_rlast), .s_rid(s_rid),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awid(s_awid),
    .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp), .s_bid(s_bid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_pass = 0;
  int n_total = 0;

  // reference model state: pending read requests per master and the round-robin pointer
  bit          pend[NM];
  logic [31:0] req_addr[NM];
  logic [7:0]  req_len[NM];
  logic [3:0]  req_id[NM];
  int          model_ptr = 0;
  int          grant_log[$];

  typedef struct {
    int          mst;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [3:0]  id;
    logic [1:0]  lresp;
    logic [1:0]  exp_done;
  } rvec_t;
  rvec_t tbl[4];

  task automatic chk(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
    n_total++;
    if (act_v !== exp_v) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act_v, exp_v, $time);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [NM-1:0] oh(input int m);
    logic [NM-1:0] v;
    v = '0;
    v[m] = 1'b1;
    return v;
  endfunction

  function automatic int model_pick();
    for (int k = 0; k < NM; k++) begin
`ifdef YSYX_23060208_ARB_RR_EN
      int idx = (model_ptr + k) % NM;
`else
      int idx = k;
`endif
      if (pend[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic raise(input int m, input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id);
    pend[m] = 1'b1;
    req_addr[m] = addr;
    req_len[m] = len;
    req_id[m] = id;
    m_araddr[m*32 +: 32] = addr;
    m_arlen[m*8 +: 8] = len;
    m_arid[m*4 +: 4] = id;
    m_arvalid[m] = 1'b1;
  endtask

  // DUT is expected in the address phase for master m; serves the burst as the slave
  task automatic serve_read(input int m, input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                            input logic [1:0] lresp, input bit stall, input logic [NM-1:0] exp_oh);
    logic [63:0] d;
    chk("done_clear", rd_done, 0);
    chk("ar_valid", s_arvalid, 1);
    chk("ar_addr", s_araddr, addr);
    chk("ar_len", s_arlen, len);
    chk("ar_id", s_arid, id);
    chk("ar_size", s_arsize, 3'd3);
    chk("ar_burst", s_arburst, 2'd1);
    chk("arready_gated", m_arready, 0);
    s_arready = 1'b1;
    #1;
    chk("arready_route", m_arready, exp_oh);
    tick();
    s_arready = 1'b0;
    m_arvalid[m] = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      d = {$urandom, $urandom};
      s_rvalid = 1'b1;
      s_rdata = d;
      s_rlast = (b == int'(len));
      s_rresp = (b == int'(len)) ? lresp : 2'b00;
      s_rid = id;
      if (stall && $urandom_range(0, 1) == 1) begin
        m_rready[m] = 1'b0;
        #1;
        chk("rready_stall", s_rready, 0);
        chk("rvalid_stall", m_rvalid, exp_oh);
        tick();
      end
      m_rready[m] = 1'b1;
      #1;
      chk("r_route", m_rvalid, exp_oh);
      chk("r_ready", s_rready, 1);
      chk("r_data", m_rdata, d);
      chk("r_id", m_rid, id);
      chk("r_last", m_rlast, (b == int'(len)));
      if (b == int'(len)) chk("r_resp", m_rresp, lresp);
      chk("no_early_done", rd_done, 0);
      tick();
    end
    s_rvalid = 1'b0;
    s_rlast = 1'b0;
    m_rready[m] = 1'b0;
    #1;
    chk("rd_done", rd_done, exp_oh);
    chk("ar_idle", s_arvalid, 0);
    chk("r_idle", m_rvalid, 0);
  endtask

  task automatic grant_and_serve(input logic [1:0] lresp, input bit stall);
    int w;
    tick();
    w = model_pick();
    if (w < 0) begin
      $display("FAIL model_pick: no pending request");
      $fatal(1, "no pending request");
    end
    model_ptr = (w + 1) % NM;
    grant_log.push_back(w);
    serve_read(w, req_addr[w], req_len[w], req_id[w], lresp, stall, oh(w));
    pend[w] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rem[NM];
    int exp_seq[6];
    logic [63:0] rd0;

    tbl[0] = '{1, 32'h8000_0000, 8'd3, 4'h5, 2'b00, 2'b10};
    tbl[1] = '{0, 32'h3000_0010, 8'd0, 4'h2, 2'b00, 2'b01};
    tbl[2] = '{0, 32'h1000_0040, 8'd1, 4'h3, 2'b10, 2'b01};
    tbl[3] = '{1, 32'hA000_0000, 8'd7, 4'hF, 2'b11, 2'b10};
`ifdef YSYX_23060208_ARB_RR_EN
    exp_seq = '{0, 1, 0, 1, 0, 1};
`else
    exp_seq = '{0, 0, 0, 0, 0, 1};
`endif

    reset = 1'b0;
    m_arvalid = '0; m_araddr = '0; m_arid = '0; m_arlen = '0;
    m_arsize = {3'd3, 3'd3}; m_arburst = {2'd1, 2'd1};
    m_rready = '0;
    m_awvalid = '0; m_awaddr = '0; m_awid = '0; m_awlen = '0;
    m_awsize = {3'd2, 3'd2}; m_awburst = {2'd1, 2'd1};
    m_wvalid = '0; m_wdata = '0; m_wstrb = '0; m_wlast = '0; m_bready = '0;
    s_arready = 0; s_rvalid = 0; s_rdata = '0; s_rresp = '0; s_rlast = 0; s_rid = '0;
    s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = '0; s_bid = '0;
    for (int i = 0; i < NM; i++) pend[i] = 1'b0;

    // reset state
    #12;
    chk("rst_arvalid", s_arvalid, 0);
    chk("rst_awvalid", s_awvalid, 0);
    chk("rst_wvalid", s_wvalid, 0);
    chk("rst_rdone", rd_done, 0);
    chk("rst_wdone", wr_done, 0);
    reset = 1'b1;
    tick();
    chk("idle_arready", m_arready, 0);
    chk("idle_rvalid", m_rvalid, 0);
    chk("idle_bvalid", m_bvalid, 0);
    chk("idle_rready", s_rready, 0);

    // contention: both masters keep requesting, five reads each
    rem[0] = 5; rem[1] = 5;
    for (int r = 0; r < 10; r++) begin
      for (int m = 0; m < NM; m++)
        if (!pend[m] && rem[m] > 0) begin
          raise(m, 32'h1000_0000 * (m + 1) + 32'(r * 16), 8'd1, 4'(m + 1));
          rem[m]--;
        end
      grant_and_serve(2'b00, 1'b0);
    end
    for (int i = 0; i < 6; i++) chk($sformatf("contention_grant%0d", i), grant_log[i], exp_seq[i]);

    // directed single reads, including error responses on the last beat
    for (int i = 0; i < 4; i++) begin
      raise(tbl[i].mst, tbl[i].addr, tbl[i].len, tbl[i].id);
      tick();
      model_ptr = (tbl[i].mst + 1) % NM;
      serve_read(tbl[i].mst, tbl[i].addr, tbl[i].len, tbl[i].id, tbl[i].lresp, 1'b0, tbl[i].exp_done);
      pend[tbl[i].mst] = 1'b0;
    end

    // write whose W beat completes three cycles before AW is accepted
    m_awvalid[0] = 1'b1; m_awaddr[31:0] = 32'h8000_0100; m_awlen[7:0] = 8'd0; m_awid[3:0] = 4'h7;
    m_wvalid[0] = 1'b1; m_wdata[63:0] = 64'h1234; m_wstrb[7:0] = 8'h0F; m_wlast[0] = 1'b1;
    m_bready[0] = 1'b1;
    s_awready = 1'b0; s_wready = 1'b1;
    tick();
    chk("aw_valid", s_awvalid, 1);
    chk("aw_addr", s_awaddr, 32'h8000_0100);
    chk("aw_id", s_awid, 4'h7);
    chk("aw_len", s_awlen, 0);
    chk("aw_size", s_awsize, 3'd2);
    chk("aw_burst", s_awburst, 2'd1);
    chk("w_valid", s_wvalid, 1);
    chk("w_data", s_wdata, 64'h1234);
    chk("w_strb", s_wstrb, 8'h0F);
    chk("w_last", s_wlast, 1);
    chk("w_ready_route", m_wready, 2'b01);
    chk("awready_gated", m_awready, 0);
    tick();
    m_wvalid[0] = 1'b0;
    #1;
    chk("w_masked_after_last", s_wvalid, 0);
    chk("aw_still_valid", s_awvalid, 1);
    chk("no_early_b", m_bvalid, 0);
    tick();
    tick();
    s_awready = 1'b1;
    #1;
    chk("awready_route", m_awready, 2'b01);
    tick();
    m_awvalid[0] = 1'b0; s_awready = 1'b0;
    s_bvalid = 1'b1; s_bresp = 2'b00; s_bid = 4'h7;
    #1;
    chk("aw_done_masked", s_awvalid, 0);
    chk("b_route", m_bvalid, 2'b01);
    chk("b_ready", s_bready, 1);
    chk("b_id", m_bid, 4'h7);
    chk("b_resp", m_bresp, 0);
    tick();
    chk("wr_done", wr_done, 2'b01);
    chk("single_b", s_bready, 0);
    chk("single_b_route", m_bvalid, 0);
    s_bvalid = 1'b0; m_bready = '0; m_wlast = '0;
    tick();
    chk("wr_done_pulse", wr_done, 0);

    // concurrent: master 0 reads three beats while master 1 writes two
    raise(0, 32'h2000_0000, 8'd2, 4'h1);
    m_awvalid[1] = 1'b1; m_awaddr[63:32] = 32'h4000_0000; m_awlen[15:8] = 8'd1; m_awid[7:4] = 4'h9;
    tick();
    model_ptr = 1;
    s_arready = 1'b1; s_awready = 1'b1; s_wready = 1'b1;
    m_wvalid[1] = 1'b1; m_wdata[127:64] = 64'hAAAA_0001; m_wstrb[15:8] = 8'hFF; m_wlast[1] = 1'b0;
    #1;
    chk("cc_ar_aw_valid", {s_arvalid, s_awvalid}, 2'b11);
    chk("cc_ar_addr", s_araddr, 32'h2000_0000);
    chk("cc_aw_addr", s_awaddr, 32'h4000_0000);
    chk("cc_arready", m_arready, 2'b01);
    chk("cc_awready", m_awready, 2'b10);
    chk("cc_wready0", m_wready, 2'b10);
    chk("cc_wdata0", s_wdata, 64'hAAAA_0001);
    tick();
    m_arvalid[0] = 1'b0; m_awvalid[1] = 1'b0; s_arready = 1'b0; s_awready = 1'b0;
    pend[0] = 1'b0;
    m_wdata[127:64] = 64'hAAAA_0002; m_wlast[1] = 1'b1;
    rd0 = 64'h5555_0000;
    s_rvalid = 1'b1; s_rdata = rd0; s_rlast = 1'b0; s_rresp = 2'b00; s_rid = 4'h1; m_rready[0] = 1'b1;
    #1;
    chk("cc_r0_route", m_rvalid, 2'b01);
    chk("cc_w1_valid", s_wvalid, 1);
    chk("cc_wdata1", s_wdata, 64'hAAAA_0002);
    chk("cc_wready1", m_wready, 2'b10);
    chk("cc_aw_masked", s_awvalid, 0);
    tick();
    m_wvalid[1] = 1'b0; m_wlast[1] = 1'b0;
    s_rdata = rd0 + 1;
    s_bvalid = 1'b1; s_bid = 4'h9; s_bresp = 2'b00; m_bready[1] = 1'b1;
    #1;
    chk("cc_r1_route", m_rvalid, 2'b01);
    chk("cc_b_route", m_bvalid, 2'b10);
    chk("cc_b_ready", s_bready, 1);
    chk("cc_w_masked", s_wvalid, 0);
    tick();
    s_bvalid = 1'b0; m_bready = '0;
    s_rdata = rd0 + 2; s_rlast = 1'b1;
    #1;
    chk("cc_wr_done", wr_done, 2'b10);
    chk("cc_r2_route", m_rvalid, 2'b01);
    chk("cc_b_idle", m_bvalid, 0);
    tick();
    s_rvalid = 1'b0; s_rlast = 1'b0; m_rready = '0;
    #1;
    chk("cc_rd_done", rd_done, 2'b01);
    chk("cc_wr_done_pulse", wr_done, 0);

    // randomized read traffic with ready stalls against the arbitration model
    for (int r = 0; r < 25; r++) begin
      int any;
      any = 0;
      for (int m = 0; m < NM; m++) begin
        if (!pend[m] && $urandom_range(0, 1) == 1)
          raise(m, $urandom, 8'($urandom_range(0, 5)), 4'($urandom));
        if (pend[m]) any = 1;
      end
      if (any == 0) raise(int'($urandom_range(0, NM - 1)), $urandom, 8'($urandom_range(0, 5)), 4'($urandom));
      grant_and_serve(2'($urandom), 1'b1);
    end
    for (int m = 0; m < NM; m++) begin
      m_arvalid[m] = 1'b0;
      pend[m] = 1'b0;
    end
    tick();

    // reset asserted during beat 2 of a 4-beat burst
    raise(0, 32'h6000_0000, 8'd3, 4'h4);
    tick();
    chk("rst_test_ar", s_arvalid, 1);
    s_arready = 1'b1;
    tick();
    s_arready = 1'b0; m_arvalid[0] = 1'b0; pend[0] = 1'b0;
    s_rvalid = 1'b1; s_rlast = 1'b0; s_rdata = 64'h1; m_rready[0] = 1'b1;
    tick();
    s_rdata = 64'h2;
    #1;
    chk("rst_test_beat2", m_rvalid, 2'b01);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_async_rvalid", m_rvalid, 0);
    chk("rst_async_rready", s_rready, 0);
    chk("rst_async_arvalid", s_arvalid, 0);
    chk("rst_async_done", rd_done, 0);
    s_rvalid = 1'b0; m_rready = '0;
    tick();
    chk("rst_no_done", rd_done, 0);
    reset = 1'b1;
    model_ptr = 0;
    tick();
    chk("rst_release_done", rd_done, 0);
    chk("rst_release_idle", s_arvalid, 0);
    raise(1, 32'h7000_0000, 8'd1, 4'hC);
    grant_and_serve(2'b00, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
